// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_controller
//  Description : Pipeline hazard control. Resolves load-use stalls, taken
//                branch and jump flushes, and data-memory wait states, and
//                keeps saturating stall/flush event counters plus a sticky
//                memory-timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_controller #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MAX_WAIT          = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_ID,
  input  logic [4:0]  rt_ID,
  input  logic        uses_rt_ID,
  input  logic        memRead_EX,
  input  logic [4:0]  rd_EX,
  input  logic        branch_taken_EX,
  input  logic        jump_ID,
  input  logic        mem_busy,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        Mux_enable_ID,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        pipe_hold,
  output logic        mem_timeout,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  // Bubbles still owed after the first one, which is inserted from RUN.
  localparam logic [2:0] C_STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [7:0] C_WAIT_LIMIT   = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [2:0]  stall_cnt_q, stall_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_count_q, stall_count_d;
  logic [15:0] flush_count_q, flush_count_d;

  logic luh;
  logic eval_run;

  assign luh = memRead_EX && (rd_EX != 5'd0) &&
               ((rd_EX == rs_ID) || (uses_rt_ID && (rd_EX == rt_ID)));

  // Next-state, pipeline control outputs and event counters.
  always_comb begin
    PC_write      = 1'b1;
    IF_ID_write   = 1'b1;
    Mux_enable_ID = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_flush   = 1'b0;
    pipe_hold     = 1'b0;
    state_d       = state_q;
    stall_cnt_d   = stall_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    eval_run      = 1'b0;

    if (rst) begin
      // Pipeline is quiesced while reset is held; state is cleared in the flops.
      PC_write      = 1'b0;
      IF_ID_write   = 1'b0;
      Mux_enable_ID = 1'b0;
    end else begin
      case (state_q)
        LOAD_STALL: begin
          // Branch/jump ignored here: EX and ID carry a bubble or frozen instruction.
          PC_write      = 1'b0;
          IF_ID_write   = 1'b0;
          Mux_enable_ID = 1'b0;
          if (mem_busy) begin
            pipe_hold = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q - 3'd1;
            if (stall_cnt_q == 3'd1) begin
              state_d = RUN;
            end
          end
        end
        MEM_WAIT: begin
          if (mem_busy) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            pipe_hold   = 1'b1;
            if (wait_cnt_q == C_WAIT_LIMIT) begin
              mem_timeout_d = 1'b1;
            end
            if (wait_cnt_q != 8'hFF) begin
              wait_cnt_d = wait_cnt_q + 8'd1;
            end
          end else begin
            eval_run = 1'b1;
          end
        end
        default: begin
          if (mem_busy) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            pipe_hold   = 1'b1;
            wait_cnt_d  = 8'd1;
            state_d     = MEM_WAIT;
          end else begin
            eval_run = 1'b1;
          end
        end
      endcase

      // Shared RUN priority list (memory idle): branch, load-use, jump.
      if (eval_run) begin
        state_d = RUN;
        if (branch_taken_EX) begin
          // A coincident load-use is squashed along with the ID instruction.
          IF_ID_flush = 1'b1;
          ID_EX_flush = 1'b1;
        end else if (luh) begin
          PC_write      = 1'b0;
          IF_ID_write   = 1'b0;
          Mux_enable_ID = 1'b0;
          if (LOAD_STALL_CYCLES > 1) begin
            stall_cnt_d = C_STALL_RELOAD;
            state_d     = LOAD_STALL;
          end
        end else if (jump_ID) begin
          IF_ID_flush = 1'b1;
        end
      end
    end

    stall_count_d = stall_count_q;
    if (!PC_write && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
    flush_count_d = flush_count_q;
    if (IF_ID_flush && (flush_count_q != 16'hFFFF)) begin
      flush_count_d = flush_count_q + 16'd1;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      stall_cnt_q   <= 3'd0;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= 16'd0;
      flush_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      stall_cnt_q   <= stall_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule
`default_nettype wire
